// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
//   state_t : sequencer FSM states
//   NIBBLE  : width of one external ALU pass
//   W       : register / operand width (two nibbles)
//   NREG    : register file depth
package alu_seq_pkg;

    localparam int NIBBLE = 4;
    localparam int W      = 8;
    localparam int NREG   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU sequencer: NREG x W flops with asynchronous
// active-low clear, one synchronous write port, two combinational read ports.
//   clk, rst_n        : clock, async active-low clear
//   we, waddr, wdata  : write port
//   raddr_a, rdata_a  : read port A
//   raddr_b, rdata_b  : read port B
module alu_regfile
    import alu_seq_pkg::*;
#(
    parameter int RF_NREG = NREG,
    parameter int RF_W    = W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(RF_NREG)-1:0] waddr,
    input  logic [RF_W-1:0]            wdata,
    input  logic [$clog2(RF_NREG)-1:0] raddr_a,
    input  logic [$clog2(RF_NREG)-1:0] raddr_b,
    output logic [RF_W-1:0]            rdata_a,
    output logic [RF_W-1:0]            rdata_b
);

    logic [RF_W-1:0] regs [RF_NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Control/operand stage for a 4-bit slice ALU. Accepts one command at a time,
// runs each 8-bit ALU operation as a low-nibble pass followed by a high-nibble
// pass on the external combinational ALU, writes the result back and returns
// it with carry/zero flags.
//   cmd_*  : command handshake (load immediate or ALU operation)
//   alu_*  : external ALU operands/controls (out) and result/carry (in)
//   rsp_*  : response handshake with result, carry and zero flags
//
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   LO    | low-nibble pass driven on the ALU
//   HI    | high-nibble pass driven, carry chained from LO
//   WB    | response valid, waiting for rsp_ready
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREG = 4,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_load,
    input  logic [W-1:0] cmd_imm,
    input  logic [3:0]   cmd_sel,
    input  logic         cmd_cin,
    input  logic         cmd_sin,
    input  logic [1:0]   cmd_srca,
    input  logic [1:0]   cmd_srcb,
    input  logic [1:0]   cmd_dst,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [3:0]   alu_s,
    output logic         alu_c0,
    output logic         alu_il,
    output logic         alu_ir,
    input  logic [3:0]   alu_f,
    input  logic         alu_c8,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_carry,
    output logic         rsp_zero
);

    state_t         state;
    logic [3:0]     opa_hi;
    logic [3:0]     opb_hi;
    logic           opa_b3;
    logic           sin_q;
    logic [1:0]     dst_q;
    logic [3:0]     res_lo;

    logic           rf_we;
    logic [1:0]     rf_waddr;
    logic [W-1:0]   rf_wdata;
    logic [W-1:0]   rd_a;
    logic [W-1:0]   rd_b;

    assign cmd_ready = (state == IDLE);

    // Loads write at the fire edge; ALU results write at the HI->WB edge,
    // so the register file is current before the next command can fire.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = cmd_dst;
        rf_wdata = cmd_imm;
        if (state == HI) begin
            rf_we    = 1'b1;
            rf_waddr = dst_q;
            rf_wdata = {alu_f, res_lo};
        end else if (state == IDLE && cmd_valid && cmd_load) begin
            rf_we    = 1'b1;
        end
    end

    alu_regfile #(
        .RF_NREG (NREG),
        .RF_W    (W)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (cmd_srca),
        .raddr_b (cmd_srcb),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    // ALU controls are registered: they are loaded with the LO values at the
    // fire edge and with the HI values at the LO->HI edge, so alu_c0 in HI is
    // the carry-out captured from the low pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opa_hi    <= '0;
            opb_hi    <= '0;
            opa_b3    <= 1'b0;
            sin_q     <= 1'b0;
            dst_q     <= '0;
            res_lo    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            alu_c0    <= 1'b0;
            alu_il    <= 1'b0;
            alu_ir    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            rsp_data  <= cmd_imm;
                            rsp_carry <= 1'b0;
                            rsp_zero  <= (cmd_imm == '0);
                            rsp_valid <= 1'b1;
                            state     <= WB;
                        end else begin
                            opa_hi <= rd_a[7:4];
                            opb_hi <= rd_b[7:4];
                            opa_b3 <= rd_a[3];
                            sin_q  <= cmd_sin;
                            dst_q  <= cmd_dst;
                            alu_a  <= rd_a[3:0];
                            alu_b  <= rd_b[3:0];
                            alu_s  <= cmd_sel;
                            alu_c0 <= cmd_cin;
                            alu_il <= cmd_sin;
                            alu_ir <= rd_a[4];
                            state  <= LO;
                        end
                    end
                end
                LO: begin
                    res_lo <= alu_f;
                    alu_a  <= opa_hi;
                    alu_b  <= opb_hi;
                    alu_c0 <= alu_c8;
                    alu_il <= opa_b3;
                    alu_ir <= sin_q;
                    state  <= HI;
                end
                HI: begin
                    rsp_data  <= {alu_f, res_lo};
                    rsp_carry <= alu_c8;
                    rsp_zero  <= ({alu_f, res_lo} == '0);
                    rsp_valid <= 1'b1;
                    alu_a     <= '0;
                    alu_b     <= '0;
                    alu_s     <= '0;
                    alu_c0    <= 1'b0;
                    alu_il    <= 1'b0;
                    alu_ir    <= 1'b0;
                    state     <= WB;
                end
                WB: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
